// File: rtl/alu_divider.sv
// Multi-cycle radix-2 restoring divider for the ALU_OP_DIV slot (DIV/DIVU/REM/REMU).
// One quotient bit per cycle, then a sign-fix cycle; ALU-style {N,Z,C,V} flags.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       div_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? ((~x) + WIDTH'(1)) : x;
  endfunction

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res, input logic ovf);
    return {res[WIDTH-1], (res == '0), 1'b0, ovf};
  endfunction

  logic [1:0]       state_r;
  logic             want_rem_r;
  logic             sq_r;
  logic             sr_r;
  logic             ovf_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s;
  logic             is_signed_s;
  logic             want_rem_s;
  logic             op2_zero_s;
  logic             op1_min_s;
  logic [WIDTH-1:0] dbz_res_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] fix_res_s;

  // Operation decode; unknown selects fall back to DIVU.
  always_comb begin
    is_signed_s = 1'b0;
    want_rem_s  = 1'b0;
    case (div_control)
      4'b1100: begin is_signed_s = 1'b1; want_rem_s = 1'b0; end
      4'b1101: begin is_signed_s = 1'b0; want_rem_s = 1'b0; end
      4'b1110: begin is_signed_s = 1'b1; want_rem_s = 1'b1; end
      4'b1111: begin is_signed_s = 1'b0; want_rem_s = 1'b1; end
      default: begin is_signed_s = 1'b0; want_rem_s = 1'b0; end
    endcase
  end

  // Accept qualification, divide-by-zero result and the per-cycle trial subtraction.
  always_comb begin
    accept_s    = start & ((state_r == S_IDLE) | (state_r == S_DONE));
    op2_zero_s  = (op2 == '0);
    op1_min_s   = (op1 == {1'b1, {(WIDTH-1){1'b0}}});
    dbz_res_s   = want_rem_s ? op1 : '1;
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    trial_s     = rem_shift_s - {1'b0, dvs_r};
    if (want_rem_r) begin
      fix_res_s = neg_if(rem_r, sr_r);
    end else begin
      fix_res_s = neg_if(quo_r, sq_r);
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      want_rem_r  <= 1'b0;
      sq_r        <= 1'b0;
      sr_r        <= 1'b0;
      ovf_r       <= 1'b0;
      quo_r       <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      result      <= '0;
      flags       <= 4'b0000;
      div_by_zero <= 1'b0;
    end else if (accept_s) begin
      want_rem_r  <= want_rem_s;
      sq_r        <= is_signed_s & (op1[WIDTH-1] ^ op2[WIDTH-1]);
      sr_r        <= is_signed_s & op1[WIDTH-1];
      // MIN / -1 in signed mode: the natural result is MIN, flagged only for DIV.
      ovf_r       <= is_signed_s & ~want_rem_s & op1_min_s & (op2 == '1);
      quo_r       <= neg_if(op1, is_signed_s & op1[WIDTH-1]);
      dvs_r       <= neg_if(op2, is_signed_s & op2[WIDTH-1]);
      rem_r       <= '0;
      cnt_r       <= CW'(WIDTH);
      div_by_zero <= op2_zero_s;
      if (op2_zero_s) begin
        result  <= dbz_res_s;
        flags   <= make_flags(dbz_res_s, 1'b0);
        state_r <= S_DONE;
      end else begin
        state_r <= S_ITER;
      end
    end else begin
      case (state_r)
        S_ITER: begin
          if (!trial_s[WIDTH]) begin
            rem_r <= trial_s[WIDTH-1:0];
          end else begin
            rem_r <= rem_shift_s[WIDTH-1:0];
          end
          quo_r <= {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_ITER;
          end
        end
        S_FIX: begin
          result  <= fix_res_s;
          flags   <= make_flags(fix_res_s, ovf_r);
          state_r <= S_DONE;
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r == S_ITER) | (state_r == S_FIX);
  assign done = (state_r == S_DONE);

endmodule

// File: tb/tb_alu_divider.sv
// Directed, table-driven bench for alu_divider (WIDTH = 32) plus hand-written
// sequences for ignored start, back-to-back launch and mid-operation reset.
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic [3:0]  div_control = 4'b0000;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        div_by_zero;

  int tests = 0;
  int failed = 0;

  alu_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op1(op1), .op2(op2),
    .div_control(div_control), .busy(busy), .done(done), .result(result),
    .flags(flags), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a launch on the falling edge; returns just after the accept edge.
  task automatic launch(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; div_control = ctl; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; busy must stay high meanwhile.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic bok;
    int total;

    vecs[0]  = '{4'b1101, 32'd100,       32'd7,        32'd14,        4'b0000, 1'b0, 33};
    vecs[1]  = '{4'b1111, 32'd100,       32'd7,        32'd2,         4'b0000, 1'b0, 33};
    vecs[2]  = '{4'b1100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD,  4'b1000, 1'b0, 33};
    vecs[3]  = '{4'b1110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF,  4'b1000, 1'b0, 33};
    vecs[4]  = '{4'b1101, 32'h00001234,  32'd0,        32'hFFFFFFFF,  4'b1000, 1'b1, 0};
    vecs[5]  = '{4'b1111, 32'h00001234,  32'd0,        32'h00001234,  4'b0000, 1'b1, 0};
    vecs[6]  = '{4'b1100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  4'b1001, 1'b0, 33};
    vecs[7]  = '{4'b1110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000,  4'b0100, 1'b0, 33};
    vecs[8]  = '{4'b1101, 32'd5,         32'd7,        32'd0,         4'b0100, 1'b0, 33};
    vecs[9]  = '{4'b0000, 32'hFFFFFFFF,  32'h10,       32'h0FFFFFFF,  4'b0000, 1'b0, 33};
    vecs[10] = '{4'b1100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD,  4'b1000, 1'b0, 33};
    vecs[11] = '{4'b1110, 32'd7,         32'hFFFFFFFE, 32'd1,         4'b0000, 1'b0, 33};
    vecs[12] = '{4'b1101, 32'h80000000,  32'hFFFFFFFF, 32'd0,         4'b0100, 1'b0, 33};
    vecs[13] = '{4'b1100, 32'h80000000,  32'd1,        32'h80000000,  4'b1000, 1'b0, 33};

    // Reset state
    #12;
    check("reset_busy",   {31'd0, busy},        32'd0);
    check("reset_done",   {31'd0, done},        32'd0);
    check("reset_result", result,               32'd0);
    check("reset_flags",  {28'd0, flags},       32'd0);
    check("reset_dbz",    {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].ctl, vecs[i].a, vecs[i].b);
      wait_done(lat, bok);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_while_running", i), {31'd0, bok}, 32'd1);
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].flg});
      check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_result_held", i), result, vecs[i].res);
    end

    // start during ITER is ignored
    launch(4'b1101, 32'd10, 32'd3);
    total = 0;
    repeat (4) begin @(posedge clk); #1; total++; end
    launch(4'b1101, 32'd99, 32'd9);
    total++;
    wait_done(lat, bok);
    check("ignored_start_latency", total + lat, 33);
    check("ignored_start_result", result, 32'd3);

    // Back-to-back: start accepted during the done cycle
    launch(4'b1101, 32'd99, 32'd9);
    check("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(lat, bok);
    check("b2b_latency", lat, 33);
    check("b2b_busy", {31'd0, bok}, 32'd1);
    check("b2b_result", result, 32'd11);

    // Reset mid-operation
    launch(4'b1101, 32'd1000, 32'd10);
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, busy},        32'd0);
    check("midrst_done",   {31'd0, done},        32'd0);
    check("midrst_result", result,               32'd0);
    check("midrst_flags",  {28'd0, flags},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bok = 1'b0;
    end
    check("midrst_no_done_after_release", {31'd0, bok}, 32'd1);
    launch(4'b1101, 32'd6, 32'd3);
    wait_done(lat, bok);
    check("post_reset_latency", lat, 33);
    check("post_reset_result", result, 32'd2);
    check("post_reset_flags", {28'd0, flags}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
